point_tracker: RTL and testbench
================================

# point_tracker

Parametrised multi-blob centroid tracker for the D8M binarised video path. It clusters the `binary_flag` pixels of each frame into up to `NUM_BLOBS` bounding-box slots and accumulates per-slot sums. At each VGA vertical-sync rising edge it snapshots the slots, computes integer centroids with a sequential divider, and streams them out over a valid/ready handshake. It sits after the binarisation stage and replaces the single-point median finder.

## Interface
- `NUM_BLOBS`, 4: number of cluster slots (1..16).
- `MERGE_DIST`, 8: pixel margin added around a slot's bounding box for membership.
- `MIN_PIXELS`, 4: slots with a smaller count are not emitted.
- `CNT_W`, 20: pixel-count width per slot.
- `SUM_W`, 36: coordinate-sum width per slot. Must satisfy SUM_W ≥ 16+CNT_W.
- `clk`  in  1  pixel clock.
- `rst`  in  1  reset, asynchronous, active-high. One clock; this reset is the only reset.
- `vga_vs`  in  1  vertical sync. Its rising edge ends the frame.
- `binary_flag`  in  1  current pixel is foreground.
- `h_cnt`, `v_cnt`  in  16 each  current pixel coordinates.
- `pt_valid`  out  1  centroid record available.
- `pt_ready`  in  1  consumer accepts the record.
- `pt_h`, `pt_v`  out  16 each  centroid, truncated quotient.
- `pt_count`  out  CNT_W  pixels in the slot.
- `pt_index`  out  4  slot number.
- `frame_done`  out  1  one-cycle pulse after the last record of a frame.
- `pt_num`  out  5  records emitted this frame. Valid with `frame_done`.
- `overflow`  out  1  frame had dropped pixels. Valid with `frame_done`.
- `frame_drop`  out  1  sticky. Set when a result frame was aborted. Cleared only by `rst`.

## Operation
- Vsync edge detection: `vs_d` is a registered copy of `vga_vs`. An edge is `vga_vs & ~vs_d`.
- Active bank holds per slot: `used`, `cnt`, `sum_h`, `sum_v`, `hmin`, `hmax`, `vmin`, `vmax`.
- Pixel handling (`binary_flag`=1):
  - Slot k matches if `hmin`−MERGE_DIST ≤ h ≤ `hmax`+MERGE_DIST, and likewise for v. The subtraction saturates at 0 and the addition saturates at 0xFFFF.
  - Lowest-index matching used slot wins. It adds to `cnt`, `sum_h` and `sum_v`, and extends the bbox.
  - With no match, the lowest-index unused slot is allocated with bbox = point and cnt = 1.
  - With no match and no free slot, the pixel is dropped and the frame's overflow flag is set.
  - When `cnt` is at its maximum, the pixel is ignored for that slot: count, sums and bbox are all left unchanged.
- Vsync edge:
  - Active bank and overflow flag copy to the result bank.
  - Active bank clears.
  - A flagged pixel in the same cycle belongs to the new frame and is applied to the cleared bank.
- Result FSM states: IDLE, LOAD, DIV, EMIT, DONE.
  - IDLE → LOAD on vsync edge, with slot pointer = 0.
  - LOAD: if the slot is unused or `cnt` < MIN_PIXELS, advance the pointer; otherwise start both dividers and go to DIV. Once the pointer passes NUM_BLOBS−1, go to DONE.
  - DIV: lasts SUM_W cycles, then go to EMIT.
  - EMIT: hold `pt_valid` and the record stable until `pt_ready`. On the handshake, increment `pt_num` and return to LOAD with the next slot.
  - DONE: pulse `frame_done`, then go to IDLE.
- A vsync edge in any non-IDLE state aborts the current frame with no `frame_done`. It sets `frame_drop`, drops `pt_valid` and restarts at LOAD using the new snapshot.
- Division: unsigned restoring, sum/cnt, one quotient bit per cycle. The 16 LSBs of the quotient are output. `cnt` is never 0 in DIV.

## Timing
- Reset values:
  - all outputs 0;
  - bank cleared;
  - FSM in IDLE;
  - `vs_d`=0.
- Vsync edge sampled at cycle T:
  - LOAD at T+1.
  - If slot 0 qualifies, DIV runs T+2..T+1+SUM_W and `pt_valid` rises at T+2+SUM_W.
  - Each skipped slot costs 1 cycle.
- Handshake:
  - A record transfers when `pt_valid` & `pt_ready` at a rising edge.
  - `pt_valid` never depends combinationally on `pt_ready`.
- `frame_done` is asserted one cycle after the final LOAD that finds no further slots.
- Reset asserted mid-frame or mid-division immediately clears everything. No partial record is emitted.

## Structure
- Package `point_tracker_pkg` holds:
  - FSM state enum;
  - slot record typedef (cnt, sums, bbox, used);
  - a width-check localparam for SUM_W ≥ 16+CNT_W.
- Sub-module `centroid_divider` (parametrised SUM_W/CNT_W; start/busy/done, 16-bit quotient) is instantiated twice, for H and V.
- Slot matching is a combinational priority encoder in the top level.

## Test plan
- Single blob, 3×3 pixels at h=100..102, v=50..52, then vsync with `pt_ready`=1 → one record: h=101, v=51, count=9, index=0, then `frame_done` with `pt_num`=1, `overflow`=0.
- Two blobs 200 px apart, each of 9 pixels → records index 0 and 1 with the correct centroids; `pt_num`=2.
- Five separated blobs with NUM_BLOBS=4 → 4 records; fifth blob dropped; `overflow`=1.
- Blob of 2 pixels with MIN_PIXELS=4 → no record; `frame_done` with `pt_num`=0.
- Hold `pt_ready`=0 for 20 cycles while `pt_valid` is high → record stays stable and transfers exactly once. Then issue a second vsync during DIV → `frame_drop`=1, no `frame_done` for the aborted frame, and the new frame's records are emitted.
- Flagged pixel coincident with a vsync edge → counted in the next frame only. Assert `rst` during EMIT → `pt_valid`=0 the same cycle.

Source files
------------

// File: rtl/point_tracker_pkg.sv
// Shared types for point_tracker: result FSM states, per-slot bounding box,
// width sanity check and the merge-window helper.
package point_tracker_pkg;

  localparam int COORD_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_DIV  = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  typedef struct packed {
    logic               used;
    logic [COORD_W-1:0] hmin;
    logic [COORD_W-1:0] hmax;
    logic [COORD_W-1:0] vmin;
    logic [COORD_W-1:0] vmax;
  } slot_box_t;

  // A full slot of maximum coordinates must never overflow its sum register.
  function automatic bit widths_ok(input int sum_w, input int cnt_w);
    return sum_w >= COORD_W + cnt_w;
  endfunction

  // Window widened by margin on both sides, saturating at 0 and 0xFFFF.
  function automatic logic in_window(input logic [COORD_W-1:0] p,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi,
                                     input logic [COORD_W-1:0] margin);
    logic [COORD_W-1:0] lo_s;
    logic [COORD_W-1:0] hi_s;
    logic [COORD_W:0]   hi_ext;
    lo_s   = (lo >= margin) ? lo - margin : '0;
    hi_ext = {1'b0, hi} + {1'b0, margin};
    hi_s   = hi_ext[COORD_W] ? '1 : hi_ext[COORD_W-1:0];
    return (p >= lo_s) && (p <= hi_s);
  endfunction

endpackage

// File: rtl/point_tracker_divider.sv
// centroid_divider: unsigned restoring divider, one quotient bit per cycle,
// SUM_W cycles per division; exposes the low 16 quotient bits.
module centroid_divider #(
  parameter int SUM_W = 36,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [15:0]      quotient
);

  localparam int STEP_W = $clog2(SUM_W + 1);

  logic [SUM_W-1:0]  q_r;
  logic [CNT_W-1:0]  rem_r;
  logic [CNT_W-1:0]  dvs_r;
  logic [STEP_W-1:0] step_r;
  logic [CNT_W:0]    rem_sh;
  logic [CNT_W-1:0]  diff;
  logic              fits;

  // The partial remainder stays below the divisor, so the low CNT_W bits of
  // the difference are exact whenever it fits.
  always_comb begin
    rem_sh = {rem_r, q_r[SUM_W-1]};
    fits   = rem_sh >= {1'b0, dvs_r};
    diff   = rem_sh[CNT_W-1:0] - dvs_r;
  end

  assign done     = busy && (step_r == STEP_W'(1));
  assign quotient = q_r[15:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r    <= '0;
      rem_r  <= '0;
      dvs_r  <= '0;
      step_r <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      q_r    <= dividend;
      rem_r  <= '0;
      dvs_r  <= divisor;
      step_r <= STEP_W'(SUM_W);
      busy   <= 1'b1;
    end else if (busy) begin
      q_r    <= {q_r[SUM_W-2:0], fits};
      rem_r  <= fits ? diff : rem_sh[CNT_W-1:0];
      step_r <= step_r - STEP_W'(1);
      if (step_r == STEP_W'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/point_tracker.sv
// point_tracker: clusters foreground pixels into bounding-box slots per frame
// and streams integer centroids of the previous frame on a valid/ready port.
module point_tracker
  import point_tracker_pkg::*;
#(
  parameter int NUM_BLOBS  = 4,
  parameter int MERGE_DIST = 8,
  parameter int MIN_PIXELS = 4,
  parameter int CNT_W      = 20,
  parameter int SUM_W      = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vga_vs,
  input  logic             binary_flag,
  input  logic [15:0]      h_cnt,
  input  logic [15:0]      v_cnt,
  output logic             pt_valid,
  input  logic             pt_ready,
  output logic [15:0]      pt_h,
  output logic [15:0]      pt_v,
  output logic [CNT_W-1:0] pt_count,
  output logic [3:0]       pt_index,
  output logic             frame_done,
  output logic [4:0]       pt_num,
  output logic             overflow,
  output logic             frame_drop,
  output state_t           dbg_state
);

  localparam bit              WIDTHS_OK = widths_ok(SUM_W, CNT_W);
  localparam int              IDX_W     = (NUM_BLOBS > 1) ? $clog2(NUM_BLOBS) : 1;
  localparam logic [15:0]     MARGIN    = 16'(MERGE_DIST);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PIXELS);
  localparam logic [4:0]      LAST_PTR  = 5'(NUM_BLOBS - 1);

  if (!WIDTHS_OK) begin : g_width_error
    $error("point_tracker: SUM_W must be at least 16 + CNT_W");
  end

  // Active bank (current frame) and result bank (previous frame).
  slot_box_t        box       [NUM_BLOBS];
  logic [CNT_W-1:0] cnt       [NUM_BLOBS];
  logic [SUM_W-1:0] sum_h     [NUM_BLOBS];
  logic [SUM_W-1:0] sum_v     [NUM_BLOBS];
  logic             res_used  [NUM_BLOBS];
  logic [CNT_W-1:0] res_cnt   [NUM_BLOBS];
  logic [SUM_W-1:0] res_sum_h [NUM_BLOBS];
  logic [SUM_W-1:0] res_sum_v [NUM_BLOBS];
  logic             ovf, res_ovf;
  logic             vs_d, vs_edge;

  logic             hit, free_found, upd, alloc, drop;
  logic [IDX_W-1:0] hit_idx, free_idx, alloc_idx;

  assign vs_edge = vga_vs & ~vs_d;

  // Priority encoders: descending scan leaves the lowest index in place.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int k = NUM_BLOBS - 1; k >= 0; k--) begin
      if (box[k].used && in_window(h_cnt, box[k].hmin, box[k].hmax, MARGIN)
                      && in_window(v_cnt, box[k].vmin, box[k].vmax, MARGIN)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(k);
      end
      if (!box[k].used) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(k);
      end
    end
    upd       = binary_flag && !vs_edge && hit && (cnt[hit_idx] != CNT_MAX);
    alloc     = binary_flag && (vs_edge || (!hit && free_found));
    alloc_idx = vs_edge ? '0 : free_idx;
    drop      = binary_flag && !vs_edge && !hit && !free_found;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d    <= 1'b0;
      ovf     <= 1'b0;
      res_ovf <= 1'b0;
      for (int k = 0; k < NUM_BLOBS; k++) begin
        box[k]       <= '0;
        cnt[k]       <= '0;
        sum_h[k]     <= '0;
        sum_v[k]     <= '0;
        res_used[k]  <= 1'b0;
        res_cnt[k]   <= '0;
        res_sum_h[k] <= '0;
        res_sum_v[k] <= '0;
      end
    end else begin
      vs_d <= vga_vs;
      if (vs_edge) begin
        res_ovf <= ovf;
        ovf     <= 1'b0;
        for (int k = 0; k < NUM_BLOBS; k++) begin
          res_used[k]  <= box[k].used;
          res_cnt[k]   <= cnt[k];
          res_sum_h[k] <= sum_h[k];
          res_sum_v[k] <= sum_v[k];
          box[k]       <= '0;
          cnt[k]       <= '0;
          sum_h[k]     <= '0;
          sum_v[k]     <= '0;
        end
      end else if (drop) begin
        ovf <= 1'b1;
      end
      if (upd) begin
        cnt[hit_idx]   <= cnt[hit_idx] + CNT_W'(1);
        sum_h[hit_idx] <= sum_h[hit_idx] + SUM_W'(h_cnt);
        sum_v[hit_idx] <= sum_v[hit_idx] + SUM_W'(v_cnt);
        if (h_cnt < box[hit_idx].hmin) box[hit_idx].hmin <= h_cnt;
        if (h_cnt > box[hit_idx].hmax) box[hit_idx].hmax <= h_cnt;
        if (v_cnt < box[hit_idx].vmin) box[hit_idx].vmin <= v_cnt;
        if (v_cnt > box[hit_idx].vmax) box[hit_idx].vmax <= v_cnt;
      end
      // On a vsync edge this lands in the freshly cleared slot 0.
      if (alloc) begin
        box[alloc_idx]   <= '{used: 1'b1, hmin: h_cnt, hmax: h_cnt, vmin: v_cnt, vmax: v_cnt};
        cnt[alloc_idx]   <= CNT_W'(1);
        sum_h[alloc_idx] <= SUM_W'(h_cnt);
        sum_v[alloc_idx] <= SUM_W'(v_cnt);
      end
    end
  end

  // Result FSM. Handshake: a record moves when pt_valid && pt_ready at a
  // rising edge; pt_valid is purely a function of state, never of pt_ready.
  state_t           state, state_nx;
  logic [4:0]       ptr, ptr_nx, num_nx;
  logic [IDX_W-1:0] ptr_idx;
  logic             slot_ok, div_start;
  logic             busy_h, busy_v, done_h, done_v;
  logic [15:0]      q_h, q_v;

  assign ptr_idx = ptr[IDX_W-1:0];
  assign slot_ok = res_used[ptr_idx] && (res_cnt[ptr_idx] >= MIN_CNT);

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    num_nx    = pt_num;
    div_start = 1'b0;
    if (vs_edge) begin
      state_nx = ST_LOAD;
      ptr_nx   = '0;
      num_nx   = '0;
    end else begin
      case (state)
        ST_IDLE: state_nx = ST_IDLE;
        ST_LOAD: begin
          if (ptr > LAST_PTR) begin
            state_nx = ST_DONE;
          end else if (slot_ok) begin
            div_start = 1'b1;
            state_nx  = ST_DIV;
          end else begin
            ptr_nx = ptr + 5'd1;
          end
        end
        ST_DIV: if ((done_h && done_v) || !(busy_h || busy_v)) state_nx = ST_EMIT;
        ST_EMIT: begin
          if (pt_ready) begin
            num_nx   = pt_num + 5'd1;
            ptr_nx   = ptr + 5'd1;
            state_nx = ST_LOAD;
          end
        end
        ST_DONE: state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      pt_num     <= '0;
      frame_drop <= 1'b0;
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      pt_num <= num_nx;
      if (vs_edge && state != ST_IDLE) frame_drop <= 1'b1;
    end
  end

  centroid_divider #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div_h (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (res_sum_h[ptr_idx]),
    .divisor  (res_cnt[ptr_idx]),
    .busy     (busy_h),
    .done     (done_h),
    .quotient (q_h)
  );

  centroid_divider #(.SUM_W(SUM_W), .CNT_W(CNT_W)) u_div_v (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (res_sum_v[ptr_idx]),
    .divisor  (res_cnt[ptr_idx]),
    .busy     (busy_v),
    .done     (done_v),
    .quotient (q_v)
  );

  assign pt_valid   = (state == ST_EMIT);
  assign pt_h       = q_h;
  assign pt_v       = q_v;
  assign pt_count   = res_cnt[ptr_idx];
  assign pt_index   = ptr[3:0];
  assign frame_done = (state == ST_DONE) && !vs_edge;
  assign overflow   = res_ovf;
  assign dbg_state  = state;

endmodule

// File: tb/tb_point_tracker.sv
// Self-checking bench for point_tracker: blob-level model feeds a record
// queue and a frame queue, popped when the DUT hands over records / frame_done.
module tb_point_tracker;
  import point_tracker_pkg::*;

  localparam int NB   = 4;
  localparam int MINP = 4;
  localparam int CW   = 20;
  localparam int SW   = 36;
  localparam int RW   = 4 + CW + 16 + 16;

  logic          clk = 1'b0;
  logic          rst, vga_vs, binary_flag, pt_ready;
  logic [15:0]   h_cnt, v_cnt;
  logic          pt_valid, frame_done, overflow, frame_drop;
  logic [15:0]   pt_h, pt_v;
  logic [CW-1:0] pt_count;
  logic [3:0]    pt_index;
  logic [4:0]    pt_num;
  state_t        dbg_state;

  point_tracker #(.NUM_BLOBS(NB), .MERGE_DIST(8), .MIN_PIXELS(MINP),
                  .CNT_W(CW), .SUM_W(SW)) dut (
    .clk(clk), .rst(rst), .vga_vs(vga_vs), .binary_flag(binary_flag),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_h(pt_h), .pt_v(pt_v), .pt_count(pt_count), .pt_index(pt_index),
    .frame_done(frame_done), .pt_num(pt_num), .overflow(overflow),
    .frame_drop(frame_drop), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard state
  logic [RW-1:0] exp_q[$];
  logic [5:0]    exp_f_q[$];
  int            n_vec = 0;
  int            n_err = 0;

  // per-frame blob model
  int     m_n;
  int     m_cnt[8];
  longint m_sh[8];
  longint m_sv[8];
  bit     m_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_n = 0;
    m_ovf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_cnt[i] = 0; m_sh[i] = 0; m_sv[i] = 0;
    end
  endtask

  task automatic model_add(input int b, input int h, input int v);
    if (b < NB) begin
      m_cnt[b]++; m_sh[b] += h; m_sv[b] += v;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic px(input int b, input int h, input int v);
    binary_flag = 1'b1; h_cnt = 16'(h); v_cnt = 16'(v);
    tick();
    binary_flag = 1'b0;
    model_add(b, h, v);
  endtask

  task automatic blob(input int h0, input int v0, input int w, input int ht);
    int b;
    b = m_n++;
    for (int y = 0; y < ht; y++)
      for (int x = 0; x < w; x++) px(b, h0 + x, v0 + y);
  endtask

  task automatic end_frame();
    int k, lim;
    k = 0;
    lim = (m_n < NB) ? m_n : NB;
    for (int b = 0; b < lim; b++) begin
      if (m_cnt[b] >= MINP) begin
        exp_q.push_back({4'(b), CW'(m_cnt[b]), 16'(m_sh[b] / m_cnt[b]), 16'(m_sv[b] / m_cnt[b])});
        k++;
      end
    end
    exp_f_q.push_back({5'(k), m_ovf});
    model_reset();
  endtask

  task automatic vsync();
    vga_vs = 1'b1;
    tick();
    vga_vs = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && exp_f_q.size() == 0) break;
      tick();
    end
    check("drain_pending", 64'(exp_q.size() + exp_f_q.size()), 64'd0);
    repeat (3) tick();
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (pt_valid) break;
      tick();
    end
    check("valid_arrives", 64'(pt_valid), 64'd1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin : mon
    logic [RW-1:0] e;
    logic [5:0]    f;
    if (!rst) begin
      if (pt_valid && pt_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("record", 64'({pt_index, pt_count, pt_h, pt_v}), 64'(e));
      end
      if (frame_done) begin
        f = (exp_f_q.size() > 0) ? exp_f_q.pop_front() : 'x;
        check("frame_num_ovf", 64'({pt_num, overflow}), 64'(f));
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; vga_vs = 1'b0; binary_flag = 1'b0; pt_ready = 1'b1;
    h_cnt = '0; v_cnt = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(pt_valid), 64'd0);
    check("rst_done", 64'(frame_done), 64'd0);
    check("rst_num", 64'(pt_num), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_drop", 64'(frame_drop), 64'd0);
    check("rst_rec", 64'({pt_index, pt_count, pt_h, pt_v}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    tick();

    // single 3x3 blob, with first-record latency
    blob(100, 50, 3, 3);
    end_frame();
    vsync();
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      n = i;
      if (pt_valid) break;
    end
    check("latency", 64'(n), 64'(SW + 1));
    drain(1000);

    // two blobs at the saturating corners of the coordinate space
    blob(0, 0, 3, 3);
    blob(65533, 65533, 3, 3);
    end_frame();
    vsync();
    drain(1000);

    // five blobs, fifth has no slot
    for (int i = 0; i < 5; i++) blob(100 + 100 * i, 100, 3, 3);
    end_frame();
    vsync();
    drain(1000);

    // tiny blob only
    blob(50, 50, 2, 1);
    end_frame();
    vsync();
    drain(1000);

    // MIN_PIXELS boundary and truncating centroid: 2 and 3 pixels skipped, 4 kept
    blob(10, 10, 2, 1);
    blob(100, 10, 3, 1);
    n = m_n++;
    px(n, 200, 20); px(n, 201, 20); px(n, 201, 21); px(n, 201, 21);
    end_frame();
    vsync();
    drain(1000);

    // backpressure: record must hold for 20 cycles
    pt_ready = 1'b0;
    blob(300, 300, 3, 3);
    blob(400, 400, 2, 2);
    end_frame();
    vsync();
    wait_valid(200);
    for (int i = 0; i < 20; i++) begin
      check("stall_valid", 64'(pt_valid), 64'd1);
      if (exp_q.size() > 0) check("stall_rec", 64'({pt_index, pt_count, pt_h, pt_v}), 64'(exp_q[0]));
      tick();
    end
    pt_ready = 1'b1;
    drain(1000);

    // vsync during DIV aborts the frame
    check("drop_before", 64'(frame_drop), 64'd0);
    blob(300, 300, 3, 3);
    model_reset();
    vsync();
    blob(600, 100, 3, 3);
    check("in_div", 64'(dbg_state), 64'(ST_DIV));
    end_frame();
    vsync();
    check("drop_after", 64'(frame_drop), 64'd1);
    drain(1000);

    // flagged pixel on the vsync edge belongs to the next frame
    blob(500, 400, 3, 3);
    end_frame();
    vga_vs = 1'b1; binary_flag = 1'b1; h_cnt = 16'd20; v_cnt = 16'd30;
    tick();
    vga_vs = 1'b0; binary_flag = 1'b0;
    n = m_n++;
    model_add(n, 20, 30);
    px(n, 21, 30); px(n, 20, 31); px(n, 21, 31);
    drain(1000);
    end_frame();
    vsync();
    drain(1000);

    // reset while a record is offered
    pt_ready = 1'b0;
    blob(100, 100, 3, 3);
    end_frame();
    vsync();
    wait_valid(200);
    #2 rst = 1'b1;
    #1;
    check("rst_emit_valid", 64'(pt_valid), 64'd0);
    check("rst_emit_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_emit_drop", 64'(frame_drop), 64'd0);
    check("rst_emit_num", 64'(pt_num), 64'd0);
    exp_q.delete();
    exp_f_q.delete();
    model_reset();
    tick();
    rst = 1'b0;
    pt_ready = 1'b1;
    tick();

    // recovery after reset
    blob(1000, 1000, 3, 3);
    end_frame();
    vsync();
    drain(1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
